// File: rtl/lpt_fifo_controller.sv
// PCI I/O-BAR parallel-port controller: SPP register set plus transmit FIFO and Centronics strobe sequencer.
// Reads are combinational in the access state; FIFO pushes past full are dropped and set OVF.
// Optional LPT_BUSY_TIMEOUT_EN: S_WAITBUSY aborts after 16'hFFFF cycles and flags PXR[6].
module lpt_fifo_controller #(
  parameter int FIFO_DEPTH = 16,
  parameter int SETUP_CYC  = 4,
  parameter int STROBE_CYC = 8,
  parameter int HOLD_CYC   = 4,
  parameter int CNT_W      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        irdy,
  input  logic [3:0]  in_command,
  input  logic [7:0]  in_addr_bar_offset_w_io,
  input  logic        is_LPT_configured,
  input  logic        is_LPT_iospace,
  input  logic [7:0]  addr_data_buf_in_byte,
  output logic [31:0] out_add_data_io,
  output logic        device_ready,
  output logic        control,
  output logic        interrupt_pin,
  input  logic        ACK,
  input  logic        BUSY,
  input  logic        PE,
  input  logic        SELT,
  input  logic        ERR,
  output logic        STROBE,
  output logic        AFD,
  output logic        INIT,
  output logic        SIN,
  inout  wire  [7:0]  data
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYC - 1);

  typedef enum logic [3:0] {
    B_RESET, B_IDLE,
    B_W_PDR, B_W_PCR, B_W_PXR, B_W_PUSH,
    B_R_PIR, B_R_PSR, B_R_PCR, B_R_PXR, B_R_FSR
  } bus_state_t;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_WAITBUSY
  } seq_state_t;

  bus_state_t bus_state, bus_next;
  seq_state_t seq_state;

  logic [4:0] sync1, sync2;
  logic       ack_s, busy_s, pe_s, selt_s, err_s, ack_d;

  logic [7:0] pdr, pcr, pxr, pir;
  logic       ovf, irq;

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    fifo_cnt;
  logic             fifo_full, fifo_empty;
  logic             push_req, push_ok, pop;

  logic [CNT_W-1:0] seq_cnt;
  logic [7:0]       latch;
  logic             strobe_q, seq_start, fifo_drive, tmo_fire;
  logic [7:0]       psr, fsr, rd_byte;

  // Status pin synchronisers, ordered {ACK, BUSY, PE, SELT, ERR}
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {ACK, BUSY, PE, SELT, ERR};
      sync2 <= sync1;
    end
  end

  assign {ack_s, busy_s, pe_s, selt_s, err_s} = sync2;

  function automatic logic is_read(input bus_state_t s);
    return (s == B_R_PIR) || (s == B_R_PSR) || (s == B_R_PCR) ||
           (s == B_R_PXR) || (s == B_R_FSR);
  endfunction

  always_comb begin
    bus_next = bus_state;
    case (bus_state)
      B_RESET: bus_next = B_IDLE;
      B_IDLE: begin
        if (is_LPT_configured && is_LPT_iospace && !irdy) begin
          if (in_command == 4'h3) begin
            case (in_addr_bar_offset_w_io)
              8'd0:    bus_next = B_W_PDR;
              8'd2:    bus_next = B_W_PCR;
              8'd3:    bus_next = B_W_PXR;
              8'd4:    bus_next = B_W_PUSH;
              default: bus_next = B_IDLE;
            endcase
          end else if (in_command == 4'h2) begin
            case (in_addr_bar_offset_w_io)
              8'd0:    bus_next = B_R_PIR;
              8'd1:    bus_next = B_R_PSR;
              8'd2:    bus_next = B_R_PCR;
              8'd3:    bus_next = B_R_PXR;
              8'd5:    bus_next = B_R_FSR;
              default: bus_next = B_IDLE;
            endcase
          end
        end
      end
      default: if (irdy) bus_next = B_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_state <= B_RESET;
      control   <= 1'b1;
    end else begin
      bus_state <= bus_next;
      control   <= !is_read(bus_next);
    end
  end

  assign device_ready = (bus_state == B_RESET) || (bus_state == B_IDLE);

  // Transmit FIFO; a push into a full FIFO is accepted when a pop frees a slot in the same cycle
  assign push_req   = (bus_state == B_IDLE) && (bus_next == B_W_PUSH);
  assign fifo_full  = (fifo_cnt == CW'(FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);
  assign push_ok    = push_req && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= addr_data_buf_in_byte;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign seq_start = (seq_state == S_IDLE) && pxr[0] && !fifo_empty && !busy_s && !pcr[5];
  assign pop       = seq_start;

`ifdef LPT_BUSY_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                      tmo_cnt <= '0;
    else if (seq_state == S_WAITBUSY) tmo_cnt <= tmo_cnt + 16'd1;
    else                             tmo_cnt <= '0;
  end

  assign tmo_fire = (seq_state == S_WAITBUSY) && (tmo_cnt == 16'hFFFF);
`else
  assign tmo_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seq_state <= S_IDLE;
      seq_cnt   <= '0;
      latch     <= '0;
      strobe_q  <= 1'b1;
    end else begin
      case (seq_state)
        S_IDLE: begin
          if (seq_start) begin
            seq_state <= S_SETUP;
            seq_cnt   <= '0;
            latch     <= fifo_mem[rd_ptr];
          end
        end
        S_SETUP: begin
          if (seq_cnt == SETUP_LAST) begin
            seq_state <= S_STROBE;
            seq_cnt   <= '0;
            strobe_q  <= 1'b0;
          end else begin
            seq_cnt <= seq_cnt + CNT_W'(1);
          end
        end
        S_STROBE: begin
          if (seq_cnt == STROBE_LAST) begin
            seq_state <= S_HOLD;
            seq_cnt   <= '0;
            strobe_q  <= 1'b1;
          end else begin
            seq_cnt <= seq_cnt + CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (seq_cnt == HOLD_LAST) begin
            seq_state <= S_WAITBUSY;
            seq_cnt   <= '0;
          end else begin
            seq_cnt <= seq_cnt + CNT_W'(1);
          end
        end
        S_WAITBUSY: if (!busy_s || tmo_fire) seq_state <= S_IDLE;
        default:    seq_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pdr           <= 8'hFF;
      pcr           <= 8'hC0;
      pxr           <= 8'h00;
      pir           <= 8'h00;
      ovf           <= 1'b0;
      irq           <= 1'b0;
      ack_d         <= 1'b0;
      interrupt_pin <= 1'b1;
    end else begin
      pir   <= data;
      ack_d <= ack_s;
      if (bus_state == B_W_PDR) pdr <= addr_data_buf_in_byte;
      if (bus_state == B_W_PCR) pcr <= addr_data_buf_in_byte;
      if (bus_state == B_W_PXR) begin
        pxr[7]   <= addr_data_buf_in_byte[7];
        pxr[5:0] <= addr_data_buf_in_byte[5:0];
      end
      // PXR[6] is a status flag: hardware sets it, writing a 1 clears it
      if (tmo_fire)
        pxr[6] <= 1'b1;
      else if (bus_state == B_W_PXR && addr_data_buf_in_byte[6])
        pxr[6] <= 1'b0;
      if (push_req && fifo_full && !pop)
        ovf <= 1'b1;
      else if (bus_state == B_R_FSR && irdy)
        ovf <= 1'b0;
      irq           <= irq_next();
      interrupt_pin <= !irq_next();
    end
  end

  function automatic logic irq_next();
    logic set_evt, clr_evt;
    set_evt = pcr[4] && ((ack_d && !ack_s) || tmo_fire);
    clr_evt = (bus_state == B_R_PSR) && irdy;
    return set_evt || (irq && !clr_evt);
  endfunction

  assign psr = {!busy_s, ack_s, pe_s, selt_s, err_s, 3'b111};
  assign fsr = {fifo_full, fifo_empty, ovf, 5'(fifo_cnt)};

  always_comb begin
    rd_byte = 8'h00;
    case (bus_state)
      B_R_PIR: rd_byte = pir;
      B_R_PSR: rd_byte = psr;
      B_R_PCR: rd_byte = pcr;
      B_R_PXR: rd_byte = pxr;
      B_R_FSR: rd_byte = fsr;
      default: rd_byte = 8'h00;
    endcase
  end

  assign out_add_data_io = {4{rd_byte}};

  // A byte already in flight keeps the pins until it finishes, even if FIFO mode was dropped
  assign fifo_drive = pxr[0] || (seq_state != S_IDLE);
  assign STROBE     = fifo_drive ? strobe_q : !pcr[0];
  assign AFD        = !pcr[1];
  assign INIT       = pcr[2];
  assign SIN        = !pcr[3];
  assign data       = pcr[5] ? 8'hzz : (fifo_drive ? latch : pdr);

endmodule

// File: doc/lpt_fifo_controller.md
Name: lpt_fifo_controller

Overview:
Parametrised parallel-port controller for the PCI I/O BAR window. It extends the compatibility-mode register set with a transmit FIFO and a hardware Centronics strobe sequencer. It also adds an ACK-edge interrupt and overflow status. It sits between the PCI target decode logic and the DB-25 pins.

Parameters:
FIFO_DEPTH, 16, transmit FIFO entries; power of two, minimum 2.
SETUP_CYC, 4, clk cycles of data setup before STROBE asserts; minimum 1.
STROBE_CYC, 8, clk cycles STROBE is held low; minimum 1.
HOLD_CYC, 4, clk cycles of data hold after STROBE deasserts; minimum 1.
CNT_W, 8, width of the sequencer timing counter; must hold max(SETUP_CYC, STROBE_CYC, HOLD_CYC).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
irdy  in  1  PCI IRDY#, active-low
in_command  in  4  PCI command; 4'h2 = I/O read, 4'h3 = I/O write
in_addr_bar_offset_w_io  in  8  byte offset within the BAR
is_LPT_configured  in  1  BAR programmed
is_LPT_iospace  in  1  current access hits this BAR
addr_data_buf_in_byte  in  8  write data byte
out_add_data_io  out  32  read data; selected byte replicated in all four lanes
device_ready  out  1  high when the bus FSM is in RESET or IDLE
control  out  1  registered; low while in a read state (AD drive enable)
interrupt_pin  out  1  INTx#, active-low
ACK, BUSY, PE, SELT, ERR  in  1 each  printer status pins
STROBE, AFD, INIT, SIN  out  1 each  printer control pins
data  inout  8  printer data lines

Behaviour:
- Clock and reset: clock clk; reset is asynchronous, active-low. All state is cleared on reset, including mid-transfer.
- Reset values of registers:
  - PCR = 8'hC0; PXR = 8'h00; PDR = 8'hFF.
  - FIFO empty; sticky overflow flag (OVF) = 0; interrupt pending flag (IRQ) = 0.
- Reset values of outputs:
  - STROBE = 1, AFD = 1, INIT = 0, SIN = 1.
  - interrupt_pin = 1, control = 1, out_add_data_io = 0.
- Input synchronisation: ACK, BUSY, PE, SELT and ERR each pass through a 2-flop synchroniser. All logic uses the synchronised values.
- Bus FSM states: RESET -> IDLE (unconditional).
  - In IDLE, when is_LPT_configured & is_LPT_iospace & !irdy, decode {command, offset} into an access state. Undecoded combinations stay in IDLE.
  - Write offsets: 0 = PDR, 2 = PCR, 3 = PXR, 4 = FIFO_PUSH.
  - Read offsets: 0 = PIR, 1 = PSR, 2 = PCR, 3 = PXR, 5 = FSR.
  - Every access state returns to IDLE in the cycle irdy is sampled high.
- Writes:
  - Register writes take effect on every cycle spent in the write state.
  - A FIFO push occurs exactly once, on the IDLE -> FIFO_PUSH transition.
  - A push while the FIFO is full is discarded and sets OVF.
- Read path:
  - out_add_data_io is combinational and non-zero only while in a read state; otherwise it is 0.
  - PSR = {!BUSY, ACK, PE, SELT, ERR, 3'b111}.
  - FSR = {full, empty, OVF, count[4:0]}, with count zero-extended or truncated to 5 bits.
- Read side effects (applied on leaving the read state):
  - Leaving an FSR read clears OVF.
  - Leaving a PSR read clears IRQ.
- Control pins:
  - AFD = !PCR[1], INIT = PCR[2], SIN = !PCR[3].
  - PCR[5] = 1 tristates data; PIR samples data every cycle.
- Modes (PXR[0]):
  - PXR[0] = 0 (SPP): data = PDR and STROBE = !PCR[0]; the sequencer stays idle.
  - PXR[0] = 1 (FIFO): data = the sequencer latch and STROBE is driven by the sequencer.
- Sequencer FSM states: S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_WAITBUSY.
  - S_IDLE -> S_SETUP when FIFO mode, FIFO not empty, BUSY low and PCR[5] = 0. The FIFO head pops into the latch on this transition.
  - S_SETUP lasts SETUP_CYC cycles, then S_STROBE.
  - S_STROBE drives STROBE low for STROBE_CYC cycles, then S_HOLD.
  - S_HOLD lasts HOLD_CYC cycles, then S_WAITBUSY.
  - S_WAITBUSY -> S_IDLE once BUSY is low.
- Mode change mid-byte: clearing PXR[0] mid-byte lets the current byte complete through S_WAITBUSY; the sequencer then idles.
- FIFO:
  - A simultaneous push and pop leaves count unchanged. A push to a full FIFO in the same cycle as a pop is accepted.
  - Pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
- Interrupt:
  - A falling edge of synchronised ACK with PCR[4] = 1 sets IRQ.
  - interrupt_pin = !IRQ, registered.
  - If a set event and a clear event occur in the same cycle, set wins.

Optional Feature:
LPT_BUSY_TIMEOUT_EN:
- When defined: a 16-bit counter runs while the sequencer is in S_WAITBUSY.
  - At 16'hFFFF the sequencer is forced to S_IDLE, PXR[6] is set as the timeout flag, and IRQ is set if PCR[4] = 1.
  - Writing PXR with bit6 = 1 clears the flag.
- When undefined: S_WAITBUSY waits indefinitely and PXR[6] reads 0.

Test Plan:
- Reset -> read PCR gives 32'hC0C0C0C0; interrupt_pin = 1; STROBE = 1; FSR = 8'h40.
- Set PXR = 1, push 8'hA5 with BUSY = 0 -> data = A5 for SETUP_CYC cycles, then STROBE low for exactly 8 cycles, then FIFO empty.
- Push 17 bytes with BUSY held high -> FSR reads {1,0,1,5'h10}; a second FSR read shows OVF cleared.
- PCR[4] = 1, pulse ACK low -> interrupt_pin goes low 3 cycles later (2 synchroniser stages plus the edge register); a PSR read releases it after irdy is deasserted.
- Assert reset mid-S_STROBE -> STROBE = 1 immediately, FIFO empty, bus FSM in RESET.
- With LPT_BUSY_TIMEOUT_EN defined and BUSY stuck high after a strobe -> PXR[6] = 1 after 65535 cycles; the next byte is not sent while BUSY stays high.
